// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO on an inferred simple dual-port RAM with a
//               registered read port. Supports standard read (FWFT=0) and
//               first-word-fall-through read (FWFT=1). Reports occupancy,
//               full/empty and almost-full/almost-empty status.
//               Optional sticky overflow/underflow flags are compiled in when
//               the macro SYNC_FIFO_ERR_EN is defined; otherwise both flags
//               read 0 and i_err_clr has no effect.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MEM_DEPTH  = 64,
  parameter int unsigned FWFT       = 1,
  parameter int unsigned AF_THRESH  = MEM_DEPTH - 4,
  parameter int unsigned AE_THRESH  = 4,
  parameter int unsigned ADDR_BITS  = $clog2(MEM_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_almost_full,
  output logic                  o_almost_empty,
  output logic [ADDR_BITS:0]    o_count,
  input  logic                  i_err_clr,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  // Pointers carry one extra bit so that a full RAM (difference == MEM_DEPTH)
  // is distinguishable from an empty one (difference == 0).
  localparam logic [ADDR_BITS:0] c_DEPTH = (ADDR_BITS+1)'(MEM_DEPTH);
  localparam logic [ADDR_BITS:0] c_AF    = (ADDR_BITS+1)'(AF_THRESH);
  localparam logic [ADDR_BITS:0] c_AE    = (ADDR_BITS+1)'(AE_THRESH);

  // Storage array: no reset, so it maps onto block/distributed RAM.
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic [ADDR_BITS:0]    wptr_q;
  logic [ADDR_BITS:0]    wptr_d;
  logic [ADDR_BITS:0]    rptr_q;
  logic [ADDR_BITS:0]    rptr_d;
  logic [DATA_WIDTH-1:0] rd_data_q;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_ram_rd;
  logic [ADDR_BITS:0]    w_ram_cnt;
  logic [ADDR_BITS:0]    w_count;

  // Words currently held in the RAM (not yet moved to the output register).
  assign w_ram_cnt = wptr_q - rptr_q;

  // Request qualification: a full FIFO drops writes even when a pop happens on
  // the same edge; an empty FIFO ignores reads.
  assign w_full   = (w_count == c_DEPTH);
  assign w_wr_acc = i_wr_en && !w_full;
  assign w_rd_acc = i_rd_en && !w_empty;

  generate
    if (FWFT != 0) begin : g_fwft
      // The output register acts as a one-word prefetch stage. A RAM fetch is
      // issued whenever that stage is vacant or being popped, so a stream of
      // pops drains one word per cycle without bubbles.
      logic out_valid_q;
      logic out_valid_d;

      assign w_ram_rd = (w_ram_cnt != '0) && (!out_valid_q || w_rd_acc);
      assign w_empty  = !out_valid_q;
      assign w_count  = w_ram_cnt + (ADDR_BITS+1)'(out_valid_q);

      // Output-stage occupancy: filled by a fetch, vacated by a pop.
      always_comb begin
        out_valid_d = out_valid_q;
        if (w_ram_rd) begin
          out_valid_d = 1'b1;
        end else if (w_rd_acc) begin
          out_valid_d = 1'b0;
        end
      end

      // Output-stage valid register.
      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
          out_valid_q <= 1'b0;
        end else begin
          out_valid_q <= out_valid_d;
        end
      end
    end else begin : g_std
      // Standard mode: each accepted read fetches directly into o_rd_data.
      assign w_ram_rd = w_rd_acc;
      assign w_empty  = (w_ram_cnt == '0);
      assign w_count  = w_ram_cnt;
    end
  endgenerate

  // Pointer next-state: advance on accepted write / RAM fetch.
  always_comb begin
    wptr_d = wptr_q + (ADDR_BITS+1)'(w_wr_acc);
    rptr_d = rptr_q + (ADDR_BITS+1)'(w_ram_rd);
  end

  // Pointer registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // RAM write port.
  always_ff @(posedge i_clk) begin
    if (w_wr_acc) begin
      mem_q[wptr_q[ADDR_BITS-1:0]] <= i_wr_data;
    end
  end

  // RAM registered read port; this register drives o_rd_data directly and
  // holds its value between fetches.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rd_data_q <= '0;
    end else if (w_ram_rd) begin
      rd_data_q <= mem_q[rptr_q[ADDR_BITS-1:0]];
    end
  end

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_q;
  logic overflow_d;
  logic underflow_q;
  logic underflow_d;

  // Sticky error next-state: clear first so a coincident set wins.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (i_err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (i_wr_en && w_full) begin
      overflow_d = 1'b1;
    end
    if (i_rd_en && w_empty) begin
      underflow_d = 1'b1;
    end
  end

  // Sticky error registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign o_overflow  = overflow_q;
  assign o_underflow = underflow_q;
`else
  // Error reporting compiled out; the clear input is intentionally unused.
  logic w_unused_err_clr;
  assign w_unused_err_clr = i_err_clr;
  assign o_overflow       = 1'b0;
  assign o_underflow      = 1'b0;
`endif

  assign o_rd_data      = rd_data_q;
  assign o_full         = w_full;
  assign o_empty        = w_empty;
  assign o_almost_full  = (w_count >= c_AF);
  assign o_almost_empty = (w_count <= c_AE);
  assign o_count        = w_count;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo
// Description : Self-checking bench for sync_fifo. Two instances (standard and
//               FWFT, depth 8, thresholds 4/4) are driven side by side and
//               compared against a queue-level reference model; directed
//               tables and sequences cover the corner cases. Expectations for
//               the error flags follow the SYNC_FIFO_ERR_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo;

  localparam int DEPTH = 8;
  localparam int AF    = 4;
  localparam int AE    = 4;
`ifdef SYNC_FIFO_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       err_clr;
  logic       wr_en   [2];
  logic [7:0] wr_data [2];
  logic       rd_en   [2];
  logic [7:0] rd_data [2];
  logic       full    [2];
  logic       empty   [2];
  logic       afull   [2];
  logic       aempty  [2];
  logic       ovf     [2];
  logic       unf     [2];
  logic [3:0] count   [2];

  // index 0: standard read, index 1: first-word-fall-through
  sync_fifo #(.DATA_WIDTH(8), .MEM_DEPTH(DEPTH), .FWFT(0), .AF_THRESH(AF), .AE_THRESH(AE)) u_std (
    .i_clk(clk), .i_reset_n(rst_n), .i_wr_en(wr_en[0]), .i_wr_data(wr_data[0]),
    .i_rd_en(rd_en[0]), .o_rd_data(rd_data[0]), .o_full(full[0]), .o_empty(empty[0]),
    .o_almost_full(afull[0]), .o_almost_empty(aempty[0]), .o_count(count[0]),
    .i_err_clr(err_clr), .o_overflow(ovf[0]), .o_underflow(unf[0]));

  sync_fifo #(.DATA_WIDTH(8), .MEM_DEPTH(DEPTH), .FWFT(1), .AF_THRESH(AF), .AE_THRESH(AE)) u_fwft (
    .i_clk(clk), .i_reset_n(rst_n), .i_wr_en(wr_en[1]), .i_wr_data(wr_data[1]),
    .i_rd_en(rd_en[1]), .o_rd_data(rd_data[1]), .o_full(full[1]), .o_empty(empty[1]),
    .o_almost_full(afull[1]), .o_almost_empty(aempty[1]), .o_count(count[1]),
    .i_err_clr(err_clr), .o_overflow(ovf[1]), .o_underflow(unf[1]));

  // ---------------- reference model (ring of stored words per instance) ----
  int         m_cnt   [2];
  int         m_head  [2];
  int         m_fresh [2];   // words that entered on the most recent edge
  logic [7:0] m_buf   [2][DEPTH];
  logic [7:0] m_rd    [2];   // standard mode: last word delivered
  bit         m_ovf   [2];
  bit         m_unf   [2];

  int tests = 0;
  int fails = 0;

  // FWFT: the head is visible once some stored word has sat in the FIFO for
  // at least one edge. Standard: empty means nothing stored.
  function automatic bit m_empty(int m);
    if (m == 0) return (m_cnt[m] == 0);
    return ((m_cnt[m] - m_fresh[m]) == 0);
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_cnt[m] = 0; m_head[m] = 0; m_fresh[m] = 0;
      m_rd[m] = 8'h00; m_ovf[m] = 1'b0; m_unf[m] = 1'b0;
    end
  endtask

  task automatic model_edge(int m);
    bit was_full  = (m_cnt[m] == DEPTH);
    bit was_empty = m_empty(m);
    bit wacc      = wr_en[m] && !was_full;
    bit racc      = rd_en[m] && !was_empty;
`ifdef SYNC_FIFO_ERR_EN
    if (err_clr) begin m_ovf[m] = 1'b0; m_unf[m] = 1'b0; end
    if (wr_en[m] && was_full)  m_ovf[m] = 1'b1;
    if (rd_en[m] && was_empty) m_unf[m] = 1'b1;
`endif
    if (racc) begin
      if (m == 0) m_rd[m] = m_buf[m][m_head[m]];
      m_head[m] = (m_head[m] + 1) % DEPTH;
      m_cnt[m]--;
    end
    if (wacc) begin
      m_buf[m][(m_head[m] + m_cnt[m]) % DEPTH] = wr_data[m];
      m_cnt[m]++;
    end
    m_fresh[m] = wacc ? 1 : 0;
  endtask

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_dut(string tag, int m);
    string p = $sformatf("%s.%s", tag, (m == 0) ? "std" : "fwft");
    chk({p, ".count"},  int'(count[m]),  m_cnt[m]);
    chk({p, ".empty"},  int'(empty[m]),  int'(m_empty(m)));
    chk({p, ".full"},   int'(full[m]),   int'(m_cnt[m] == DEPTH));
    chk({p, ".afull"},  int'(afull[m]),  int'(m_cnt[m] >= AF));
    chk({p, ".aempty"}, int'(aempty[m]), int'(m_cnt[m] <= AE));
    chk({p, ".ovf"},    int'(ovf[m]),    int'(m_ovf[m]));
    chk({p, ".unf"},    int'(unf[m]),    int'(m_unf[m]));
    if (m == 0)
      chk({p, ".rd_data"}, int'(rd_data[m]), int'(m_rd[m]));
    else if (!m_empty(m))
      chk({p, ".rd_data"}, int'(rd_data[m]), int'(m_buf[m][m_head[m]]));
  endtask

  // Inputs are already applied (at a falling edge); advance one rising edge
  // and check both instances at the next falling edge.
  task automatic step(string tag);
    model_edge(0);
    model_edge(1);
    @(posedge clk);
    @(negedge clk);
    check_dut(tag, 0);
    check_dut(tag, 1);
    err_clr = 1'b0;
  endtask

  task automatic setb(logic we, logic [7:0] wd, logic re);
    for (int m = 0; m < 2; m++) begin
      wr_en[m] = we; wr_data[m] = wd; rd_en[m] = re;
    end
  endtask

  // Asynchronous reset pulse placed mid-cycle; outputs checked immediately.
  task automatic do_reset(string tag);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("%s.m%0d.rst_rd_data", tag, m), int'(rd_data[m]), 0);
      check_dut(tag, m);
    end
    setb(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       we;
    logic [7:0] wd;
    logic       re;
    int         cnt;
    logic       emp;
    logic       ful;
    logic [7:0] rd;
  } vec_t;

  vec_t tbl [11];

  initial begin
    // Standard-mode table: {we, wdata, re} -> {count, empty, full, rd_data}
    tbl[0]  = '{1'b1, 8'h11, 1'b0, 1, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 8'h22, 1'b0, 2, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{1'b1, 8'h33, 1'b0, 3, 1'b0, 1'b0, 8'h00};
    tbl[3]  = '{1'b1, 8'h44, 1'b0, 4, 1'b0, 1'b0, 8'h00};
    tbl[4]  = '{1'b1, 8'h55, 1'b1, 4, 1'b0, 1'b0, 8'h11};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 3, 1'b0, 1'b0, 8'h22};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 3, 1'b0, 1'b0, 8'h22};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 2, 1'b0, 1'b0, 8'h33};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1, 1'b0, 1'b0, 8'h44};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 8'h55};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 8'h55};

    rst_n   = 1'b0;
    err_clr = 1'b0;
    setb(1'b0, 8'h00, 1'b0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("reset.m%0d.rd_data", m), int'(rd_data[m]), 0);
      check_dut("reset", m);
    end
    rst_n = 1'b1;

    // ---- table-driven vectors, including simultaneous write+read at count 4
    for (int i = 0; i < 11; i++) begin
      setb(tbl[i].we, tbl[i].wd, tbl[i].re);
      step($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.count", i),   int'(count[0]),   tbl[i].cnt);
      chk($sformatf("tbl%0d.empty", i),   int'(empty[0]),   int'(tbl[i].emp));
      chk($sformatf("tbl%0d.full", i),    int'(full[0]),    int'(tbl[i].ful));
      chk($sformatf("tbl%0d.rd_data", i), int'(rd_data[0]), int'(tbl[i].rd));
    end
    chk("tbl.underflow", int'(unf[0]), int'(ERR_ON));
    setb(1'b0, 8'h00, 1'b0);
    err_clr = 1'b1;
    step("errclr");
    chk("errclr.underflow", int'(unf[0]), 0);

    // ---- FWFT fall-through of a single word into an empty FIFO
    do_reset("r37");
    setb(1'b1, 8'hA1, 1'b0);
    step("req037.e0");
    setb(1'b0, 8'h00, 1'b0);
    step("req037.e1");
    step("req037.e2");
    chk("req037.empty",   int'(empty[1]),   0);
    chk("req037.rd_data", int'(rd_data[1]), 'hA1);
    chk("req037.count",   int'(count[1]),   1);

    // ---- FWFT back-to-back pops of 8 words
    do_reset("r38");
    for (int i = 1; i <= 8; i++) begin
      setb(1'b1, 8'(i), 1'b0);
      step("req038.wr");
    end
    step("req038.settle");
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("req038.pop%0d", i), int'(rd_data[1]), i);
      setb(1'b0, 8'h00, 1'b1);
      step("req038.rd");
    end
    chk("req038.empty", int'(empty[1]), 1);
    setb(1'b0, 8'h00, 1'b0);

    // ---- overfill: ninth write is dropped
    do_reset("r39");
    for (int i = 0; i < 9; i++) begin
      setb(1'b1, 8'h10 + 8'(i), 1'b0);
      step("req039.wr");
      if (i == 7) chk("req039.full8", int'(full[0]), 1);
    end
    chk("req039.overflow", int'(ovf[0]), int'(ERR_ON));
    for (int i = 0; i < 9; i++) begin
      setb(1'b0, 8'h00, 1'b1);
      step("req039.drain");
    end
    chk("req039.last", int'(rd_data[0]), 'h17);

    // ---- mid-operation reset at count 5, then read while empty
    do_reset("r42a");
    for (int i = 0; i < 5; i++) begin
      setb(1'b1, 8'hC0 + 8'(i), 1'b0);
      step("req042.wr");
    end
    chk("req042.count5", int'(count[0]), 5);
    do_reset("req042.rst");
    setb(1'b0, 8'h00, 1'b1);
    step("req042.rd");
    chk("req042.underflow", int'(unf[0]), int'(ERR_ON));
    setb(1'b0, 8'h00, 1'b0);

    // ---- randomized traffic with gaps, wrapping the pointers many times
    do_reset("rnd");
    for (int i = 0; i < 400; i++) begin
      for (int m = 0; m < 2; m++) begin
        int wp = (i < 200) ? 65 : 35;
        wr_en[m]   = ($urandom_range(0, 99) < wp);
        wr_data[m] = 8'($urandom);
        rd_en[m]   = ($urandom_range(0, 99) < (100 - wp));
      end
      err_clr = ($urandom_range(0, 19) == 0);
      step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter DATA_WIDTH, 8, width of each stored word.
REQ-002 Parameter MEM_DEPTH, 64, number of words; SHALL be a power of two and at least 4.
REQ-003 Parameter FWFT, 1, 1 = first-word-fall-through read; 0 = standard read with i_rd_en fetch.
REQ-004 Parameter AF_THRESH, MEM_DEPTH-4, occupancy at or above which o_almost_full asserts.
REQ-005 Parameter AE_THRESH, 4, occupancy at or below which o_almost_empty asserts.
REQ-006 Parameter ADDR_BITS, $clog2(MEM_DEPTH), RAM address width (derived).
REQ-007 i_clk  input  1  single clock for all logic; one clock, rising edge.
REQ-008 i_reset_n  input  1  reset, asynchronous assert, active-low.
REQ-009 i_wr_en  input  1  write request.
REQ-010 i_wr_data  input  DATA_WIDTH  write word.
REQ-011 i_rd_en  input  1  read request (FWFT=0) / pop acknowledge (FWFT=1).
REQ-012 o_rd_data  output  DATA_WIDTH  read word, driven from a register.
REQ-013 o_full, o_empty, o_almost_full, o_almost_empty  output  1 each  status flags.
REQ-014 o_count  output  ADDR_BITS+1  stored-word occupancy, 0..MEM_DEPTH.
REQ-015 i_err_clr  input  1  clears sticky error flags.
REQ-016 o_overflow, o_underflow  output  1 each  sticky error flags.

Function
REQ-017 Storage SHALL be an inferred simple dual-port RAM with a registered read port and no reset on the array.
REQ-018 Write and read pointers SHALL be ADDR_BITS+1 wide and wrap modulo 2*MEM_DEPTH; the RAM is addressed by the low ADDR_BITS.
REQ-019 A write is accepted on an edge where i_wr_en=1 and o_full=0; it stores i_wr_data and increments the write pointer.
REQ-020 A write while o_full=1 SHALL be dropped even if a read is accepted on the same edge.
REQ-021 A read is accepted on an edge where i_rd_en=1 and o_empty=0; a read while o_empty=1 SHALL be ignored.
REQ-022 A simultaneous accepted write and read SHALL leave o_count unchanged.
REQ-023 o_full = (o_count == MEM_DEPTH); o_almost_full = (o_count >= AF_THRESH); o_almost_empty = (o_count <= AE_THRESH).
REQ-024 FWFT=0: o_empty = (o_count == 0); o_rd_data updates 1 cycle after an accepted read and holds its value otherwise.
REQ-025 FWFT=1: o_rd_data SHALL present the head word whenever o_empty=0; i_rd_en pops it.
REQ-026 FWFT=1: a word written to an empty FIFO on edge N SHALL appear with o_empty=0 no later than after edge N+2.
REQ-027 FWFT=1: with at least 2 words stored, consecutive pops SHALL deliver one new word per cycle with no bubble.
REQ-028 FWFT=1: o_count SHALL include the word held in the output register.
REQ-029 Data order SHALL be strictly first-in first-out across pointer wrap-around.

Reset
REQ-030 While i_reset_n=0: pointers=0, o_count=0, o_empty=1, o_almost_empty=1, o_full=0, o_almost_full=0, o_rd_data=0, o_overflow=0, o_underflow=0.
REQ-031 Reset mid-operation SHALL discard all stored words; the RAM contents need not be cleared.
REQ-032 Reset deassertion SHALL take effect on the next rising i_clk edge; no request is accepted while reset is asserted.

Configuration
REQ-033 Macro SYNC_FIFO_ERR_EN defined: o_overflow sets on an edge with i_wr_en=1 and o_full=1.
REQ-034 With SYNC_FIFO_ERR_EN defined, o_underflow sets on an edge with i_rd_en=1 and o_empty=1.
REQ-035 With SYNC_FIFO_ERR_EN defined, both flags stay set until an edge with i_err_clr=1; if set and clear occur together, set wins.
REQ-036 Macro undefined: o_overflow and o_underflow tied to 0 and i_err_clr ignored; the port list is unchanged.

Verification
REQ-037 FWFT=1, DEPTH=8: write 0xA1 on edge 0 into empty FIFO -> o_empty=0 and o_rd_data=0xA1 by edge 2; o_count=1.
REQ-038 FWFT=1: write 0x01..0x08, then hold i_rd_en=1 for 8 cycles -> 0x01..0x08 are popped on consecutive cycles; o_empty=1 after the 8th pop.
REQ-039 DEPTH=8: write 9 words 0x10..0x18 with no reads -> o_full=1 after the 8th; 0x18 dropped; o_overflow=1 (macro on) or 0 (macro off).
REQ-040 FWFT=0, count=4: simultaneous write 0x55 and read -> o_count stays 4; o_rd_data = oldest word one cycle later.
REQ-041 Push/pop 20 words through DEPTH=8 with random gaps -> FIFO order preserved across wrap; AF_THRESH=4 and AE_THRESH=4 flags track o_count exactly.
REQ-042 With count=5, pulse i_reset_n low mid-cycle -> outputs take REQ-030 values immediately; a subsequent read with o_empty=1 sets o_underflow (macro on).
